idu_is_iq_n: RTL and testbench
==============================

// Module: idu_is_iq_n
// PURPOSE
//  Parametrised N-entry single-source issue queue for one execution pipe in the IDU issue stage.
//  Generalises the single-entry cp0 issue slot:
//  - DEPTH entries, generic wakeup bus count, oldest-ready select via age matrix.
//  - Downstream back-pressure.
//  Sits between rename/dispatch and the selected EXU pipe.
// PARAMETERS
//  DEPTH     4   queue entries (2..16)
//  IID_W     5   instruction-id width
//  OPC_W     7   opcode width
//  PREG_W    6   physical-register index width
//  IMM_W     64  immediate width
//  WAKE_N    10  wakeup buses (alu_is, alu_rf, alu_res, mul1-3, div1-3, lsu)
//  PIPE_BIT  0   bit of in_pipe that targets this queue
// PORTS
//  clk             in   1              clock
//  rst_clk         in   1              asynchronous active-low reset
//  rtu_global_flush in  1              flush all entries
//  y_idu_is_stall_ctrl in 1            global issue-stage stall
//  in_vld          in   1              dispatch valid
//  in_pipe         in   5              pipe one-hot
//  in_iid          in   IID_W          instruction id
//  in_opcode       in   OPC_W          opcode
//  in_psrc1_vld    in   1              source used
//  in_psrc1_ready  in   1              source already ready
//  in_psrc1        in   PREG_W         source preg
//  in_imm_vld      in   1              imm used
//  in_imm          in   IMM_W          immediate
//  wake_vld        in   WAKE_N         wakeup valid per bus
//  wake_preg       in   WAKE_N*PREG_W  wakeup preg, bus k at [k*PREG_W +: PREG_W]
//  exu_pipe_busy   in   1              pipe cannot accept this cycle
//  iq_stall_ctrl   out  1              queue full
//  iq_entry_cnt    out  $clog2(DEPTH+1) valid entries
//  iq_vld          out  1              issue valid
//  iq_iid/iq_opcode/iq_psrc1_vld/iq_psrc1/iq_imm_vld/iq_imm  out  as inputs  issued fields
// BEHAVIOUR
//  Reset:
//  - All valid bits, ready bits and age matrix cleared.
//  - iq_stall_ctrl=0, iq_entry_cnt=0, iq_vld=0, all issued fields 0.
//  Create:
//  - create = in_vld & in_pipe[PIPE_BIT] & ~iq_stall_ctrl & ~y_idu_is_stall_ctrl & ~rtu_global_flush.
//  - Written into the lowest-index free entry at the edge.
//  - iq_stall_ctrl = all entries valid (registered state).
//  - A slot freed by an issue in the same cycle is NOT reusable until the next cycle.
//  Ready bit:
//  - Set at create if ~in_psrc1_vld | in_psrc1_ready | (psrc1 matches any wake bus this cycle).
//  - Otherwise set at the first edge where wake_vld[k] & wake_preg[k]==psrc1.
//  Select:
//  - Entry i is selected if it is valid & ready and no other valid & ready entry is older (age[j][i]=1).
//  - On create into slot k: age[j][k]=1 for every valid j not issuing; row k cleared.
//  Issue:
//  - iq_vld = selected_any & ~exu_pipe_busy & ~rtu_global_flush; combinational, same cycle.
//  - The issued entry's valid bit is cleared at the edge.
//  - Fields are AND-gated by iq_vld, except iq_psrc1, which is ungated.
//  Latency:
//  - Create at edge N gives earliest issue in cycle N+1.
//  - Wakeup seen in cycle N gives issue in cycle N+1.
//  Flush:
//  - Clears every valid bit at the next edge; blocks create and issue that cycle.
//  - Reset asserted mid-operation asynchronously clears all state.
//  Empty: iq_vld=0. busy held: entries stay, wakeups still accumulate.
//  Count: iq_entry_cnt += create - issue; never exceeds DEPTH.
// CONFIGURATION
//  IDU_IS_IQ_INORDER_EN defined:
//  - Only the oldest valid entry may be selected.
//  - If it is not ready, iq_vld=0 (strict order, for CSR/cp0 ops).
//  Undefined: oldest-ready out-of-order select as above.
// STRUCTURE
//  - Package idu_is_pkg: IID_W/OPC_W/PREG_W/IMM_W defaults, WAKE_N, wake-bus index constants.
//  - Sub-module idu_is_iq_entry:
//    - per-entry storage, ready bit, WAKE_N-way wakeup compare.
//    - Instantiated DEPTH times via generate.
//  - Top level holds allocation, age matrix, select and output muxing.
// TESTING
//  1. Reset, then in_vld with pipe[0], psrc1_ready=1, iid=3 -> iq_vld=1 next cycle, iq_iid=3, cnt 1->0.
//  2. 4 creates with psrc1=5 not ready -> stall_ctrl=1, cnt=4.
//     Then wake_vld[2]=1, wake_preg=5 -> iids issue oldest-first over 4 cycles.
//  3. Entries iid 1 (waiting on p7) and iid 2 (ready):
//     - Default -> iid 2 issues first.
//     - IDU_IS_IQ_INORDER_EN -> nothing issues until p7 wakes, then iid 1, then iid 2.
//  4. Create with psrc1=9 while wake bus 0 carries preg 9 in the same cycle -> issues the next cycle.
//  5. Ready entry with exu_pipe_busy=1 for 3 cycles -> iq_vld=0 and entry retained; busy=0 -> issues.
//  6. 3 valid entries, rtu_global_flush with concurrent in_vld -> iq_vld=0 that cycle, cnt=0 next, no entry created.

Source files
------------

// File: rtl/idu_is_pkg.sv
// Shared constants for the IDU issue-stage issue queue: default field widths,
// wakeup bus count and the index of each wakeup bus within the bus vector.
package idu_is_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int IID_W_DEF  = 5;
    localparam int OPC_W_DEF  = 7;
    localparam int PREG_W_DEF = 6;
    localparam int IMM_W_DEF  = 64;
    localparam int WAKE_N_DEF = 10;

    // Wakeup bus positions within wake_vld / wake_preg.
    localparam int WAKE_ALU_IS  = 0;
    localparam int WAKE_ALU_RF  = 1;
    localparam int WAKE_ALU_RES = 2;
    localparam int WAKE_MUL1    = 3;
    localparam int WAKE_MUL2    = 4;
    localparam int WAKE_MUL3    = 5;
    localparam int WAKE_DIV1    = 6;
    localparam int WAKE_DIV2    = 7;
    localparam int WAKE_DIV3    = 8;
    localparam int WAKE_LSU     = 9;

endpackage

// File: rtl/idu_is_iq_entry.sv
// One issue-queue slot: valid bit, source-ready bit, instruction payload and
// the WAKE_N-way comparison of the stored source preg against the wakeup buses.
module idu_is_iq_entry
    import idu_is_pkg::*;
#(
    parameter int IID_W  = IID_W_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int PREG_W = PREG_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int WAKE_N = WAKE_N_DEF
) (
    input  logic                     clk,
    input  logic                     rst_clk,
    input  logic                     flush_i,
    input  logic                     create_i,
    input  logic                     issue_i,
    input  logic                     in_rdy_i,
    input  logic [IID_W-1:0]         in_iid_i,
    input  logic [OPC_W-1:0]         in_opcode_i,
    input  logic                     in_psrc1_vld_i,
    input  logic [PREG_W-1:0]        in_psrc1_i,
    input  logic                     in_imm_vld_i,
    input  logic [IMM_W-1:0]         in_imm_i,
    input  logic [WAKE_N-1:0]        wake_vld_i,
    input  logic [WAKE_N*PREG_W-1:0] wake_preg_i,
    output logic                     vld_o,
    output logic                     rdy_o,
    output logic [IID_W-1:0]         iid_o,
    output logic [OPC_W-1:0]         opcode_o,
    output logic                     psrc1_vld_o,
    output logic [PREG_W-1:0]        psrc1_o,
    output logic                     imm_vld_o,
    output logic [IMM_W-1:0]         imm_o
);

    logic              vld_q, vld_d;
    logic              rdy_q, rdy_d;
    logic              wake_hit;
    logic [IID_W-1:0]  iid_q;
    logic [OPC_W-1:0]  opcode_q;
    logic              psrc1_vld_q;
    logic [PREG_W-1:0] psrc1_q;
    logic              imm_vld_q;
    logic [IMM_W-1:0]  imm_q;

    // Does any active wakeup bus carry the preg this slot is waiting on?
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wake_hit = 1'b0;
        for (int k = 0; k < WAKE_N; k++) begin
            if (wake_vld_i[k] && (wake_preg_i[k*PREG_W +: PREG_W] == psrc1_q)) begin
                wake_hit = 1'b1;
            end
        end
    end

    // Next valid/ready: flush wins, then create, then issue; ready is sticky.
    always_comb begin
        vld_d = vld_q;
        rdy_d = rdy_q | wake_hit;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (create_i) begin
            vld_d = 1'b1;
            rdy_d = in_rdy_i;
        end else if (issue_i) begin
            vld_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_clk) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            rdy_q <= rdy_d;
        end
    end

    // Payload capture on create.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; it is only ever observed
        // through a selected (hence valid) slot, so reset would only cost flops.
        if (create_i) begin
            iid_q       <= in_iid_i;
            opcode_q    <= in_opcode_i;
            psrc1_vld_q <= in_psrc1_vld_i;
            psrc1_q     <= in_psrc1_i;
            imm_vld_q   <= in_imm_vld_i;
            imm_q       <= in_imm_i;
        end
    end

    assign vld_o       = vld_q;
    assign rdy_o       = rdy_q;
    assign iid_o       = iid_q;
    assign opcode_o    = opcode_q;
    assign psrc1_vld_o = psrc1_vld_q;
    assign psrc1_o     = psrc1_q;
    assign imm_vld_o   = imm_vld_q;
    assign imm_o       = imm_q;

endmodule

// File: rtl/idu_is_iq_n.sv
// DEPTH-entry single-source issue queue for one EXU pipe. Holds allocation,
// the age matrix, oldest-ready select and the issue output mux.
// Optional build macro IDU_IS_IQ_INORDER_EN: only the oldest valid entry may
// issue, and only once it is ready (strict program order for CSR/cp0 ops).
module idu_is_iq_n
    import idu_is_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int IID_W    = IID_W_DEF,
    parameter int OPC_W    = OPC_W_DEF,
    parameter int PREG_W   = PREG_W_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter int WAKE_N   = WAKE_N_DEF,
    parameter int PIPE_BIT = 0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_clk,
    input  logic                     rtu_global_flush,
    input  logic                     y_idu_is_stall_ctrl,
    input  logic                     in_vld,
    input  logic [4:0]               in_pipe,
    input  logic [IID_W-1:0]         in_iid,
    input  logic [OPC_W-1:0]         in_opcode,
    input  logic                     in_psrc1_vld,
    input  logic                     in_psrc1_ready,
    input  logic [PREG_W-1:0]        in_psrc1,
    input  logic                     in_imm_vld,
    input  logic [IMM_W-1:0]         in_imm,
    input  logic [WAKE_N-1:0]        wake_vld,
    input  logic [WAKE_N*PREG_W-1:0] wake_preg,
    input  logic                     exu_pipe_busy,
    output logic                     iq_stall_ctrl,
    output logic [CNT_W-1:0]         iq_entry_cnt,
    output logic                     iq_vld,
    output logic [IID_W-1:0]         iq_iid,
    output logic [OPC_W-1:0]         iq_opcode,
    output logic                     iq_psrc1_vld,
    output logic [PREG_W-1:0]        iq_psrc1,
    output logic                     iq_imm_vld,
    output logic [IMM_W-1:0]         iq_imm
);

    logic                 create;
    logic                 in_wake_hit;
    logic                 in_rdy;
    logic                 unused_pipe;
    logic [DEPTH-1:0]     ent_vld, ent_rdy;
    logic [DEPTH-1:0]     alloc_oh, create_oh;
    logic [DEPTH-1:0]     elig, older_oh, sel_oh, issue_oh;
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [DEPTH-1:0]     age_d [DEPTH];
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IID_W-1:0]     ent_iid       [DEPTH];
    logic [OPC_W-1:0]     ent_opcode    [DEPTH];
    logic                 ent_psrc1_vld [DEPTH];
    logic [PREG_W-1:0]    ent_psrc1     [DEPTH];
    logic                 ent_imm_vld   [DEPTH];
    logic [IMM_W-1:0]     ent_imm       [DEPTH];

    logic [IID_W-1:0]     iid_m;
    logic [OPC_W-1:0]     opcode_m;
    logic                 psrc1_vld_m;
    logic [PREG_W-1:0]    psrc1_m;
    logic                 imm_vld_m;
    logic [IMM_W-1:0]     imm_m;

    // Only PIPE_BIT steers into this queue; the other pipe bits belong elsewhere.
    assign unused_pipe = ^in_pipe;

    // Full is a registered condition, so a slot freed by this cycle's issue
    // cannot be refilled until the next cycle.
    assign iq_stall_ctrl = &ent_vld;
    assign create = in_vld & in_pipe[PIPE_BIT] & ~iq_stall_ctrl
                  & ~y_idu_is_stall_ctrl & ~rtu_global_flush;

    // Incoming source is ready if unused, already ready, or woken this cycle.
    always_comb begin
        in_wake_hit = 1'b0;
        for (int k = 0; k < WAKE_N; k++) begin
            if (wake_vld[k] && (wake_preg[k*PREG_W +: PREG_W] == in_psrc1)) begin
                in_wake_hit = 1'b1;
            end
        end
        in_rdy = ~in_psrc1_vld | in_psrc1_ready | in_wake_hit;
    end

    // Pick the lowest-index free slot for allocation.
    always_comb begin
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    assign create_oh = alloc_oh & {DEPTH{create}};

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_entry
            idu_is_iq_entry #(
                .IID_W  (IID_W),
                .OPC_W  (OPC_W),
                .PREG_W (PREG_W),
                .IMM_W  (IMM_W),
                .WAKE_N (WAKE_N)
            ) u_entry (
                .clk            (clk),
                .rst_clk        (rst_clk),
                .flush_i        (rtu_global_flush),
                .create_i       (create_oh[g]),
                .issue_i        (issue_oh[g]),
                .in_rdy_i       (in_rdy),
                .in_iid_i       (in_iid),
                .in_opcode_i    (in_opcode),
                .in_psrc1_vld_i (in_psrc1_vld),
                .in_psrc1_i     (in_psrc1),
                .in_imm_vld_i   (in_imm_vld),
                .in_imm_i       (in_imm),
                .wake_vld_i     (wake_vld),
                .wake_preg_i    (wake_preg),
                .vld_o          (ent_vld[g]),
                .rdy_o          (ent_rdy[g]),
                .iid_o          (ent_iid[g]),
                .opcode_o       (ent_opcode[g]),
                .psrc1_vld_o    (ent_psrc1_vld[g]),
                .psrc1_o        (ent_psrc1[g]),
                .imm_vld_o      (ent_imm_vld[g]),
                .imm_o          (ent_imm[g])
            );
        end
    endgenerate

    // Entries that compete on age: every valid entry in strict order,
    // otherwise only those that are already ready.
`ifdef IDU_IS_IQ_INORDER_EN
    assign elig = ent_vld;
`else
    assign elig = ent_vld & ent_rdy;
`endif

    // An entry is blocked if any other competing entry is older (age[j][i]).
    always_comb begin
        older_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && elig[j] && age_q[j][i]) begin
                    older_oh[i] = 1'b1;
                end
            end
        end
    end

    assign sel_oh   = elig & ent_rdy & ~older_oh;
    assign iq_vld   = (|sel_oh) & ~exu_pipe_busy & ~rtu_global_flush;
    assign issue_oh = sel_oh & {DEPTH{iq_vld}};

    // A new entry is younger than every surviving entry and older than none.
    always_comb begin
        age_d = age_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (create_oh[k]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[j][k] = ent_vld[j] & ~issue_oh[j];
                end
                age_d[k] = '0;
            end
        end
    end

    // Occupancy tracks creates minus issues; flush empties the queue.
    always_comb begin
        if (rtu_global_flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(create) - CNT_W'(iq_vld);
        end
    end

    // Age matrix and occupancy registers.
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            age_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            age_q <= age_d;
            cnt_q <= cnt_d;
        end
    end

    assign iq_entry_cnt = cnt_q;

    // One-hot mux of the selected entry's payload.
    always_comb begin
        iid_m       = '0;
        opcode_m    = '0;
        psrc1_vld_m = 1'b0;
        psrc1_m     = '0;
        imm_vld_m   = 1'b0;
        imm_m       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                iid_m       = iid_m       | ent_iid[i];
                opcode_m    = opcode_m    | ent_opcode[i];
                psrc1_vld_m = psrc1_vld_m | ent_psrc1_vld[i];
                psrc1_m     = psrc1_m     | ent_psrc1[i];
                imm_vld_m   = imm_vld_m   | ent_imm_vld[i];
                imm_m       = imm_m       | ent_imm[i];
            end
        end
    end

    // Issued fields are qualified by iq_vld; the source preg goes out ungated
    // so the register-file read can start as soon as an entry is selected.
    assign iq_iid       = iq_vld ? iid_m       : '0;
    assign iq_opcode    = iq_vld ? opcode_m    : '0;
    assign iq_psrc1_vld = iq_vld ? psrc1_vld_m : 1'b0;
    assign iq_imm_vld   = iq_vld ? imm_vld_m   : 1'b0;
    assign iq_imm       = iq_vld ? imm_m       : '0;
    assign iq_psrc1     = psrc1_m;

endmodule

// File: tb/tb_idu_is_iq_n.sv
// Scoreboard bench for idu_is_iq_n: a program-order queue model predicts each
// cycle's outputs; a negedge monitor pops and compares against the DUT.
module tb_idu_is_iq_n;
    import idu_is_pkg::*;

    localparam int DEPTH  = 4;
    localparam int IID_W  = 5;
    localparam int OPC_W  = 7;
    localparam int PREG_W = 6;
    localparam int IMM_W  = 64;
    localparam int WAKE_N = 10;

    logic                     clk;
    logic                     rst_clk;
    logic                     rtu_global_flush;
    logic                     y_idu_is_stall_ctrl;
    logic                     in_vld;
    logic [4:0]               in_pipe;
    logic [IID_W-1:0]         in_iid;
    logic [OPC_W-1:0]         in_opcode;
    logic                     in_psrc1_vld;
    logic                     in_psrc1_ready;
    logic [PREG_W-1:0]        in_psrc1;
    logic                     in_imm_vld;
    logic [IMM_W-1:0]         in_imm;
    logic [WAKE_N-1:0]        wake_vld;
    logic [WAKE_N*PREG_W-1:0] wake_preg;
    logic                     exu_pipe_busy;
    logic                     iq_stall_ctrl;
    logic [2:0]               iq_entry_cnt;
    logic                     iq_vld;
    logic [IID_W-1:0]         iq_iid;
    logic [OPC_W-1:0]         iq_opcode;
    logic                     iq_psrc1_vld;
    logic [PREG_W-1:0]        iq_psrc1;
    logic                     iq_imm_vld;
    logic [IMM_W-1:0]         iq_imm;

    idu_is_iq_n #(
        .DEPTH(DEPTH), .IID_W(IID_W), .OPC_W(OPC_W), .PREG_W(PREG_W),
        .IMM_W(IMM_W), .WAKE_N(WAKE_N), .PIPE_BIT(0)
    ) dut (
        .clk                 (clk),
        .rst_clk             (rst_clk),
        .rtu_global_flush    (rtu_global_flush),
        .y_idu_is_stall_ctrl (y_idu_is_stall_ctrl),
        .in_vld              (in_vld),
        .in_pipe             (in_pipe),
        .in_iid              (in_iid),
        .in_opcode           (in_opcode),
        .in_psrc1_vld        (in_psrc1_vld),
        .in_psrc1_ready      (in_psrc1_ready),
        .in_psrc1            (in_psrc1),
        .in_imm_vld          (in_imm_vld),
        .in_imm              (in_imm),
        .wake_vld            (wake_vld),
        .wake_preg           (wake_preg),
        .exu_pipe_busy       (exu_pipe_busy),
        .iq_stall_ctrl       (iq_stall_ctrl),
        .iq_entry_cnt        (iq_entry_cnt),
        .iq_vld              (iq_vld),
        .iq_iid              (iq_iid),
        .iq_opcode           (iq_opcode),
        .iq_psrc1_vld        (iq_psrc1_vld),
        .iq_psrc1            (iq_psrc1),
        .iq_imm_vld          (iq_imm_vld),
        .iq_imm              (iq_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model entry, kept in program (creation) order: index 0 is oldest.
    typedef struct {
        logic [IID_W-1:0]  iid;
        logic [OPC_W-1:0]  opc;
        logic              p1v;
        logic [PREG_W-1:0] p1;
        logic              iv;
        logic [IMM_W-1:0]  imm;
        bit                rdy;
    } ment_t;

    typedef struct {
        logic              vld;
        logic [IID_W-1:0]  iid;
        logic [OPC_W-1:0]  opc;
        logic              p1v;
        logic [PREG_W-1:0] p1;
        logic              iv;
        logic [IMM_W-1:0]  imm;
        logic [2:0]        cnt;
        logic              stall;
    } exp_t;

    ment_t mq[$];
    exp_t  sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit wake_hits(input logic [PREG_W-1:0] p);
        for (int k = 0; k < WAKE_N; k++) begin
            if (wake_vld[k] && wake_preg[k*PREG_W +: PREG_W] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int pick_idx();
`ifdef IDU_IS_IQ_INORDER_EN
        if (mq.size() > 0 && mq[0].rdy) return 0;
        return -1;
`else
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].rdy) return i;
        end
        return -1;
`endif
    endfunction

    task automatic idle();
        rtu_global_flush    = 1'b0;
        y_idu_is_stall_ctrl = 1'b0;
        in_vld              = 1'b0;
        in_pipe             = 5'd0;
        in_iid              = '0;
        in_opcode           = '0;
        in_psrc1_vld        = 1'b0;
        in_psrc1_ready      = 1'b0;
        in_psrc1            = '0;
        in_imm_vld          = 1'b0;
        in_imm              = '0;
        wake_vld            = '0;
        wake_preg           = '0;
        exu_pipe_busy       = 1'b0;
    endtask

    task automatic set_create(input int iid, input int p1, input bit p1v, input bit p1rdy);
        in_vld         = 1'b1;
        in_pipe        = 5'b00001;
        in_iid         = IID_W'(iid);
        in_opcode      = OPC_W'($urandom);
        in_psrc1_vld   = p1v;
        in_psrc1_ready = p1rdy;
        in_psrc1       = PREG_W'(p1);
        in_imm_vld     = 1'($urandom);
        in_imm         = {$urandom, $urandom};
    endtask

    // Predict this cycle's outputs, clock once, then advance the model.
    task automatic step();
        exp_t  e;
        ment_t ne;
        int    p;
        bit    iss, cr;
        p   = pick_idx();
        iss = (p >= 0) && !exu_pipe_busy && !rtu_global_flush;
        e   = '{default: '0};
        e.vld   = iss;
        e.cnt   = 3'(mq.size());
        e.stall = (mq.size() == DEPTH);
        if (p >= 0) e.p1 = mq[p].p1;
        if (iss) begin
            e.iid = mq[p].iid;
            e.opc = mq[p].opc;
            e.p1v = mq[p].p1v;
            e.iv  = mq[p].iv;
            e.imm = mq[p].imm;
        end
        sb.push_back(e);
        cr = in_vld && in_pipe[0] && (mq.size() < DEPTH) && !y_idu_is_stall_ctrl && !rtu_global_flush;
        ne.iid = in_iid;  ne.opc = in_opcode; ne.p1v = in_psrc1_vld; ne.p1 = in_psrc1;
        ne.iv  = in_imm_vld; ne.imm = in_imm;
        ne.rdy = !in_psrc1_vld || in_psrc1_ready || wake_hits(in_psrc1);
        @(posedge clk);
        if (rtu_global_flush) begin
            mq.delete();
        end else begin
            if (iss) mq.delete(p);
            foreach (mq[i]) if (wake_hits(mq[i].p1)) mq[i].rdy = 1'b1;
            if (cr) mq.push_back(ne);
        end
        #1;
    endtask

    task automatic rand_inputs();
        idle();
        in_vld         = ($urandom_range(0, 99) < 60);
        in_pipe        = 5'($urandom);
        in_pipe[0]     = ($urandom_range(0, 99) < 75);
        in_iid         = IID_W'($urandom);
        in_opcode      = OPC_W'($urandom);
        in_psrc1_vld   = ($urandom_range(0, 99) < 80);
        in_psrc1_ready = ($urandom_range(0, 99) < 25);
        in_psrc1       = PREG_W'($urandom_range(0, 15));
        in_imm_vld     = 1'($urandom);
        in_imm         = {$urandom, $urandom};
        for (int k = 0; k < WAKE_N; k++) begin
            wake_vld[k] = ($urandom_range(0, 99) < 8);
            wake_preg[k*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 15));
        end
        exu_pipe_busy       = ($urandom_range(0, 99) < 20);
        rtu_global_flush    = ($urandom_range(0, 99) < 3);
        y_idu_is_stall_ctrl = ($urandom_range(0, 99) < 10);
    endtask

    // Monitor: compare the DUT against the oldest outstanding prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("iq_vld",        64'(iq_vld),        64'(e.vld));
            check("iq_iid",        64'(iq_iid),        64'(e.iid));
            check("iq_opcode",     64'(iq_opcode),     64'(e.opc));
            check("iq_psrc1_vld",  64'(iq_psrc1_vld),  64'(e.p1v));
            check("iq_psrc1",      64'(iq_psrc1),      64'(e.p1));
            check("iq_imm_vld",    64'(iq_imm_vld),    64'(e.iv));
            check("iq_imm",        iq_imm,             e.imm);
            check("iq_entry_cnt",  64'(iq_entry_cnt),  64'(e.cnt));
            check("iq_stall_ctrl", 64'(iq_stall_ctrl), 64'(e.stall));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_clk = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        idle(); step();

        // 1: ready create issues the next cycle.
        idle(); set_create(3, 1, 1'b1, 1'b1); step();
        idle(); step(); step();

        // 2: fill with four waiting on p5, then one wake drains oldest-first.
        for (int i = 0; i < 4; i++) begin
            idle(); set_create(4 + i, 5, 1'b1, 1'b0); step();
        end
        idle(); set_create(20, 1, 1'b0, 1'b0); step();
        idle(); wake_vld[WAKE_ALU_RES] = 1'b1;
        wake_preg[WAKE_ALU_RES*PREG_W +: PREG_W] = 6'd5; step();
        idle(); repeat (5) step();

        // 3: older entry waits on p7, younger is ready.
        idle(); set_create(1, 7, 1'b1, 1'b0); step();
        idle(); set_create(2, 3, 1'b1, 1'b1); step();
        idle(); repeat (2) step();
        idle(); wake_vld[WAKE_LSU] = 1'b1;
        wake_preg[WAKE_LSU*PREG_W +: PREG_W] = 6'd7; step();
        idle(); repeat (3) step();

        // 4: wakeup in the same cycle as create.
        idle(); set_create(9, 9, 1'b1, 1'b0);
        wake_vld[WAKE_ALU_IS] = 1'b1;
        wake_preg[WAKE_ALU_IS*PREG_W +: PREG_W] = 6'd9; step();
        idle(); repeat (2) step();

        // 5: busy holds a ready entry.
        idle(); set_create(12, 2, 1'b1, 1'b1); step();
        idle(); exu_pipe_busy = 1'b1; repeat (3) step();
        idle(); repeat (2) step();

        // 6: flush with a concurrent dispatch.
        for (int i = 0; i < 3; i++) begin
            idle(); set_create(16 + i, 20, 1'b1, 1'b0); step();
        end
        idle(); set_create(30, 1, 1'b0, 1'b0); rtu_global_flush = 1'b1; step();
        idle(); repeat (2) step();

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            rand_inputs(); step();
        end

        // Asynchronous reset mid-operation.
        idle();
        rst_clk = 1'b0;
        mq.delete();
        #2;
        rst_clk = 1'b1;
        step();
        for (int n = 0; n < 400; n++) begin
            rand_inputs(); step();
        end
        idle(); repeat (4) step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
